// File: rtl/vadd_job_sequencer.sv
// Splits one vadd job into engine-sized chunks and sequences engine start/done handshakes.
// Optional job cycle counter is built only when VADD_SEQ_PERF_CNT_EN is defined.
module vadd_job_sequencer #(
  parameter int unsigned C_ADDR_WIDTH      = 64,
  parameter int unsigned C_XFER_SIZE_WIDTH = 32,
  parameter int unsigned C_MAX_CHUNK_BYTES = 4096,
  parameter int unsigned C_ALIGN_BYTES     = 64
) (
  input  logic                         ap_clk,
  input  logic                         areset,
  input  logic                         ap_start,
  output logic                         ap_idle,
  output logic                         ap_done,
  output logic                         ap_ready,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_base_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_total_bytes,
  input  logic [31:0]                  ctrl_constant,
  output logic                         eng_start,
  output logic [C_ADDR_WIDTH-1:0]      eng_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0] eng_xfer_size_in_bytes,
  output logic [31:0]                  eng_constant,
  input  logic                         eng_done,
  output logic                         err_unaligned,
  output logic [15:0]                  chunks_done,
  output logic [31:0]                  cycle_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [C_ADDR_WIDTH-1:0]      ADDR_ALIGN_MASK = C_ADDR_WIDTH'(C_ALIGN_BYTES - 1);
  localparam logic [C_XFER_SIZE_WIDTH-1:0] SIZE_ALIGN_MASK = C_XFER_SIZE_WIDTH'(C_ALIGN_BYTES - 1);
  localparam logic [C_XFER_SIZE_WIDTH-1:0] MAX_CHUNK       = C_XFER_SIZE_WIDTH'(C_MAX_CHUNK_BYTES);

  function automatic logic [C_XFER_SIZE_WIDTH-1:0] clamp_chunk(
    input logic [C_XFER_SIZE_WIDTH-1:0] bytes
  );
    return (bytes > MAX_CHUNK) ? MAX_CHUNK : bytes;
  endfunction

  logic [1:0]                   state_reg;
  logic [1:0]                   state_next;
  logic                         ap_start_r;
  logic [C_XFER_SIZE_WIDTH-1:0] remaining_reg;
  logic [C_ADDR_WIDTH-1:0]      eng_addr_reg;
  logic [C_XFER_SIZE_WIDTH-1:0] eng_size_reg;
  logic [31:0]                  eng_const_reg;
  logic                         err_reg;
  logic [15:0]                  chunks_reg;

  logic                         start_edge;
  logic                         job_accept;
  logic                         job_empty;
  logic                         job_misaligned;
  logic                         chunk_done;
  logic [C_XFER_SIZE_WIDTH-1:0] remaining_after;
  logic                         last_chunk;

  assign start_edge      = ap_start & ~ap_start_r;
  assign job_accept      = start_edge && (state_reg == S_IDLE);
  assign job_empty       = (ctrl_total_bytes == '0);
  assign job_misaligned  = ((ctrl_base_addr & ADDR_ALIGN_MASK) != '0) ||
                           ((ctrl_total_bytes & SIZE_ALIGN_MASK) != '0);
  // Completions are honoured only while a chunk is actually outstanding.
  assign chunk_done      = (state_reg == S_WAIT) && eng_done;
  assign remaining_after = remaining_reg - eng_size_reg;
  assign last_chunk      = (remaining_after == '0);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (job_accept) begin
          state_next = (job_empty || job_misaligned) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (chunk_done) begin
          state_next = last_chunk ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_reg     <= S_IDLE;
      ap_start_r    <= 1'b0;
      remaining_reg <= '0;
      eng_addr_reg  <= '0;
      eng_size_reg  <= '0;
      eng_const_reg <= '0;
      err_reg       <= 1'b0;
      chunks_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      ap_start_r <= ap_start;

      if (job_accept) begin
        eng_const_reg <= ctrl_constant;
        chunks_reg    <= '0;
        if (!job_empty) begin
          if (job_misaligned) begin
            err_reg <= 1'b1;
          end else begin
            err_reg       <= 1'b0;
            remaining_reg <= ctrl_total_bytes;
            eng_addr_reg  <= ctrl_base_addr;
            eng_size_reg  <= clamp_chunk(ctrl_total_bytes);
          end
        end
      end

      // Next chunk's address/size are loaded here so they are already valid in ISSUE.
      if (chunk_done) begin
        remaining_reg <= remaining_after;
        if (chunks_reg != 16'hFFFF) begin
          chunks_reg <= chunks_reg + 16'd1;
        end
        if (!last_chunk) begin
          eng_addr_reg <= eng_addr_reg + C_ADDR_WIDTH'(eng_size_reg);
          eng_size_reg <= clamp_chunk(remaining_after);
        end
      end
    end
  end

`ifdef VADD_SEQ_PERF_CNT_EN
  logic [31:0] cycle_count_reg;

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      cycle_count_reg <= '0;
    end else if (job_accept) begin
      cycle_count_reg <= '0;
    end else if ((state_reg != S_IDLE) && (cycle_count_reg != 32'hFFFF_FFFF)) begin
      cycle_count_reg <= cycle_count_reg + 32'd1;
    end
  end

  assign cycle_count = cycle_count_reg;
`else
  assign cycle_count = '0;
`endif

  assign ap_idle                = (state_reg == S_IDLE);
  assign ap_done                = (state_reg == S_DONE);
  assign ap_ready               = ap_done;
  assign eng_start              = (state_reg == S_ISSUE);
  assign eng_addr_offset        = eng_addr_reg;
  assign eng_xfer_size_in_bytes = eng_size_reg;
  assign eng_constant           = eng_const_reg;
  assign err_unaligned          = err_reg;
  assign chunks_done            = chunks_reg;

endmodule

// File: tb/tb_vadd_job_sequencer.sv
// Directed bench for vadd_job_sequencer: queue-based job model checked every cycle,
// plus literal per-scenario expectations. Honors VADD_SEQ_PERF_CNT_EN like the design.
module tb_vadd_job_sequencer;

  logic        ap_clk = 1'b0;
  logic        areset;
  logic        ap_start;
  logic        ap_idle, ap_done, ap_ready;
  logic [63:0] ctrl_base_addr;
  logic [31:0] ctrl_total_bytes;
  logic [31:0] ctrl_constant;
  logic        eng_start;
  logic [63:0] eng_addr_offset;
  logic [31:0] eng_xfer_size_in_bytes;
  logic [31:0] eng_constant;
  logic        eng_done;
  logic        err_unaligned;
  logic [15:0] chunks_done;
  logic [31:0] cycle_count;

  vadd_job_sequencer dut (
    .ap_clk                 (ap_clk),
    .areset                 (areset),
    .ap_start               (ap_start),
    .ap_idle                (ap_idle),
    .ap_done                (ap_done),
    .ap_ready               (ap_ready),
    .ctrl_base_addr         (ctrl_base_addr),
    .ctrl_total_bytes       (ctrl_total_bytes),
    .ctrl_constant          (ctrl_constant),
    .eng_start              (eng_start),
    .eng_addr_offset        (eng_addr_offset),
    .eng_xfer_size_in_bytes (eng_xfer_size_in_bytes),
    .eng_constant           (eng_constant),
    .eng_done               (eng_done),
    .err_unaligned          (err_unaligned),
    .chunks_done            (chunks_done),
    .cycle_count            (cycle_count)
  );

  always #5 ap_clk = ~ap_clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int eng_delay = 3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {int c; logic [63:0] a; logic [31:0] s;} start_t;
  typedef struct {logic [63:0] a; logic [31:0] s;} chunk_t;

  start_t start_log[$];
  int     done_log[$];
  int     edone_log[$];

  // Job model: list of chunks still owed, plus what the next cycle must show.
  chunk_t      m_q[$];
  bit          m_idle, m_out, m_exp_start, m_exp_done, m_err, m_prev;
  bit          m_edge, m_ns, m_nd;
  logic [15:0] m_chunks;
  logic [31:0] m_cyc, m_const, m_rem, m_sz;
  logic [63:0] m_addr;

  always @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      m_q.delete();
      m_idle = 1; m_out = 0; m_exp_start = 0; m_exp_done = 0; m_err = 0; m_prev = 0;
      m_chunks = 0; m_cyc = 0; m_const = 0;
    end else begin
      m_edge = ap_start && !m_prev;
      m_prev = ap_start;
      m_ns = 0; m_nd = 0;
      if (eng_done) edone_log.push_back(cyc);
      if (!m_idle && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (m_idle) begin
        if (m_edge) begin
          m_idle = 0; m_chunks = 0; m_cyc = 0; m_const = ctrl_constant;
          if (ctrl_total_bytes == 0) begin
            m_nd = 1;
          end else if ((ctrl_base_addr % 64) != 0 || (ctrl_total_bytes % 64) != 0) begin
            m_err = 1; m_nd = 1;
          end else begin
            m_err = 0; m_addr = ctrl_base_addr; m_rem = ctrl_total_bytes;
            while (m_rem != 0) begin
              m_sz = (m_rem > 4096) ? 32'd4096 : m_rem;
              m_q.push_back('{a: m_addr, s: m_sz});
              m_addr = m_addr + 64'(m_sz);
              m_rem  = m_rem - m_sz;
            end
            m_ns = 1;
          end
        end
      end else if (m_exp_done) begin
        m_idle = 1;
      end else if (m_out && eng_done) begin
        void'(m_q.pop_front());
        m_out = 0;
        if (m_chunks != 16'hFFFF) m_chunks = m_chunks + 1;
        if (m_q.size() == 0) m_nd = 1; else m_ns = 1;
      end
      if (m_exp_start) m_out = 1;
      m_exp_start = m_ns;
      m_exp_done  = m_nd;
      cyc++;
    end
  end

  always @(negedge ap_clk) begin
    if (!areset) begin
      chk("eng_start", eng_start, m_exp_start);
      chk("ap_done", ap_done, m_exp_done);
      chk("ap_ready", ap_ready, m_exp_done);
      chk("ap_idle", ap_idle, m_idle);
      chk("err_unaligned", err_unaligned, m_err);
      chk("chunks_done", chunks_done, m_chunks);
`ifdef VADD_SEQ_PERF_CNT_EN
      chk("cycle_count", cycle_count, m_cyc);
`else
      chk("cycle_count", cycle_count, 0);
`endif
      if ((m_exp_start || m_out) && m_q.size() > 0) begin
        chk("eng_addr_offset", eng_addr_offset, m_q[0].a);
        chk("eng_xfer_size", eng_xfer_size_in_bytes, m_q[0].s);
      end
      if (!m_idle) chk("eng_constant", eng_constant, m_const);
      if (eng_start) start_log.push_back('{c: cyc, a: eng_addr_offset, s: eng_xfer_size_in_bytes});
      if (ap_done) done_log.push_back(cyc);
    end
  end

  // Engine stand-in: answers each eng_start with eng_done eng_delay cycles later.
  initial begin
    eng_done = 1'b0;
    forever begin
      @(negedge ap_clk);
      while (eng_start === 1'b1) begin
        repeat (eng_delay) @(negedge ap_clk);
        eng_done = 1'b1;
        @(negedge ap_clk);
        eng_done = 1'b0;
      end
    end
  end

  task automatic run_job(input logic [63:0] base, input logic [31:0] total,
                         input logic [31:0] cst, input bit glitch,
                         output int t_edge, output int t_done);
    int n;
    @(negedge ap_clk);
    start_log.delete(); done_log.delete(); edone_log.delete();
    ctrl_base_addr = base; ctrl_total_bytes = total; ctrl_constant = cst;
    ap_start = 1'b1;
    t_edge = cyc;
    n = 0;
    if (glitch) begin
      repeat (3) @(negedge ap_clk);
      ap_start = 1'b0;
      @(negedge ap_clk);
      ap_start = 1'b1;
      n = 4;
    end
    while (!ap_done && n < 2000) begin
      @(negedge ap_clk);
      n++;
    end
    if (!ap_done) begin
      checks++; errors++;
      $display("FAIL job_timeout: got no ap_done required ap_done within 2000 cycles");
    end
    t_done = cyc;
    @(negedge ap_clk);
    ap_start = 1'b0;
    chk("idle_after_done", ap_idle, 1'b1);
    repeat (2) @(negedge ap_clk);
    $display("job base=0x%0h total=%0d const=%0d edge=%0d done=%0d starts=%0d err=%0b chunks=%0d cycles=%0d",
             base, total, cst, t_edge, t_done, start_log.size(), err_unaligned, chunks_done, cycle_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, d, n;
    logic [63:0] exp1_a [4] = '{64'h1000, 64'h2000, 64'h3000, 64'h4000};
    logic [63:0] exp2_a [3] = '{64'h0, 64'h1000, 64'h2000};
    logic [31:0] exp2_s [3] = '{32'd4096, 32'd4096, 32'd2048};

    areset = 1'b1; ap_start = 1'b0;
    ctrl_base_addr = '0; ctrl_total_bytes = '0; ctrl_constant = '0;
    repeat (3) @(negedge ap_clk);
    chk("rst_ap_idle", ap_idle, 1'b1);
    chk("rst_ap_done", ap_done, 1'b0);
    chk("rst_eng_start", eng_start, 1'b0);
    chk("rst_err", err_unaligned, 1'b0);
    chk("rst_chunks", chunks_done, 16'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_eng_addr", eng_addr_offset, 64'd0);
    chk("rst_eng_size", eng_xfer_size_in_bytes, 32'd0);
    areset = 1'b0;
    repeat (2) @(negedge ap_clk);

    // 1: four full chunks
    eng_delay = 3;
    run_job(64'h1000, 32'd16384, 32'd1, 1'b0, t, d);
    chk("t1_nstarts", start_log.size(), 4);
    if (start_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_addr", start_log[i].a, exp1_a[i]);
        chk("t1_size", start_log[i].s, 32'd4096);
      end
      chk("t1_first_start_lat", start_log[0].c, t + 1);
    end
    chk("t1_ndone", done_log.size(), 1);
    chk("t1_chunks", chunks_done, 16'd4);
    chk("t1_err", err_unaligned, 1'b0);
    chk("t1_const", eng_constant, 32'd1);

    // 2: short tail chunk, back-to-back issue
    run_job(64'h0, 32'd10240, 32'd7, 1'b0, t, d);
    chk("t2_nstarts", start_log.size(), 3);
    if (start_log.size() == 3 && edone_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t2_addr", start_log[i].a, exp2_a[i]);
        chk("t2_size", start_log[i].s, exp2_s[i]);
      end
      chk("t2_gap1", start_log[1].c, edone_log[0] + 1);
      chk("t2_gap2", start_log[2].c, edone_log[1] + 1);
      chk("t2_done_lat", d, edone_log[2] + 1);
    end

    // 3: zero-length job
    run_job(64'h2000, 32'd0, 32'd5, 1'b0, t, d);
    chk("t3_nstarts", start_log.size(), 0);
    chk("t3_done_lat", d, t + 1);
    chk("t3_chunks", chunks_done, 16'd0);

    // 4: misaligned base, then an aligned job clears the flag
    run_job(64'h1020, 32'd4096, 32'd2, 1'b0, t, d);
    chk("t4_err", err_unaligned, 1'b1);
    chk("t4_done_lat", d, t + 1);
    chk("t4_nstarts", start_log.size(), 0);
    run_job(64'h40, 32'd128, 32'd3, 1'b0, t, d);
    chk("t4b_err", err_unaligned, 1'b0);
    chk("t4b_nstarts", start_log.size(), 1);
    if (start_log.size() == 1) begin
      chk("t4b_addr", start_log[0].a, 64'h40);
      chk("t4b_size", start_log[0].s, 32'd128);
    end

    // 5: reset while waiting on chunk 2
    eng_delay = 5;
    @(negedge ap_clk);
    start_log.delete(); done_log.delete();
    ctrl_base_addr = 64'h0; ctrl_total_bytes = 32'd12288; ctrl_constant = 32'd4;
    ap_start = 1'b1;
    n = 0;
    while (start_log.size() < 2 && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    chk("t5_reached_chunk2", start_log.size(), 2);
    repeat (2) @(negedge ap_clk);
    #2 areset = 1'b1;
    #1;
    chk("t5_rst_eng_start", eng_start, 1'b0);
    chk("t5_rst_idle", ap_idle, 1'b1);
    chk("t5_rst_chunks", chunks_done, 16'd0);
    ap_start = 1'b0;
    @(negedge ap_clk);
    areset = 1'b0;
    repeat (10) @(negedge ap_clk);
    chk("t5_no_restart", start_log.size(), 2);
    chk("t5_no_done", done_log.size(), 0);
    chk("t5_still_idle", ap_idle, 1'b1);
    run_job(64'h0, 32'd8192, 32'd6, 1'b0, t, d);
    chk("t5_new_nstarts", start_log.size(), 2);
    chk("t5_new_chunks", chunks_done, 16'd2);

    // 6: cycle counter, with a start edge while busy
    eng_delay = 10;
    run_job(64'h8000, 32'd8192, 32'd9, 1'b1, t, d);
    chk("t6_nstarts", start_log.size(), 2);
    chk("t6_ndone", done_log.size(), 1);
    if (start_log.size() == 2) chk("t6_spacing", start_log[1].c - start_log[0].c, 11);
`ifdef VADD_SEQ_PERF_CNT_EN
    chk("t6_cycle_count", cycle_count, 32'd23);
`else
    chk("t6_cycle_count", cycle_count, 32'd0);
`endif
    repeat (5) @(negedge ap_clk);
    chk("t6_no_retrigger", ap_idle, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
